// File: rtl/rotate_sequencer_pkg.sv
// Shared definitions for the rotate sequencer: state encodings and default sizes.
package rotate_sequencer_pkg;

    localparam int DEFAULT_N = 16;
    localparam int DEFAULT_M = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rotate_step.sv
// Combinational one-bit rotation of an N-bit word; dir=0 rotates right, dir=1 rotates left.
module rotate_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] d,
    input  logic         dir,
    output logic [N-1:0] q
);

    // Single-bit rotate, wrapping the bit shifted out back into the vacated end
    always_comb begin
        q = d;
        if (dir) begin
            q = {d[N-2:0], d[N-1]};
        end else begin
            q = {d[0], d[N-1:1]};
        end
    end

endmodule

// File: rtl/rotate_sequencer.sv
// Multi-cycle rotator: accepts an operand, rotates it one bit per clock for
// 'amount' cycles, then holds the result until downstream takes it.
module rotate_sequencer
    import rotate_sequencer_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int M = DEFAULT_M
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] i0,
    input  logic [M-1:0] amount,
    input  logic         dir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    state_t         state;
    logic [M-1:0]   count;
    logic           dir_q;
    logic [N-1:0]   stepped;

    rotate_step #(.N(N)) u_step (
        .d   (result),
        .dir (dir_q),
        .q   (stepped)
    );

    // Sequencer FSM: accept in IDLE, step in ROTATE until the count runs out, hold in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            count  <= '0;
            dir_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        result <= i0;
                        dir_q  <= dir;
                        count  <= amount;
                        state  <= (amount == '0) ? DONE : ROTATE;
                    end
                end
                ROTATE: begin
                    result <= stepped;
                    count  <= count - M'(1);
                    if (count == M'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake/status outputs are pure decodes of the registered state
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer: directed cases plus randomized
// operations compared against an arithmetic rotation model.
module tb_rotate_sequencer;

    localparam int N = 16;
    localparam int M = 4;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] i0;
    logic [M-1:0] amount;
    logic         dir;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] exp_res;
    int           exp_lat;
    int           hold_n;

    rotate_sequencer #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i0        (i0),
        .amount    (amount),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, need completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: rotate right by k is rotate left by N-k; one shift-or per op
    function automatic logic [N-1:0] ref_rot(input logic [N-1:0] x, input int k, input logic d);
        int l;
        l = d ? k : (N - k) % N;
        if (l == 0) return x;
        return (x << l) | (x >> (N - l));
    endfunction

    task automatic junk_inputs();
        in_valid = 1'($urandom);
        i0       = N'($urandom);
        amount   = M'($urandom);
        dir      = 1'($urandom);
    endtask

    task automatic drive_op(input logic [N-1:0] v, input int amt, input logic d, input int hold);
        in_valid  = 1'b1;
        i0        = v;
        amount    = M'(amt);
        dir       = d;
        out_ready = (hold == 0);
        exp_res   = ref_rot(v, amt, d);
        exp_lat   = amt;
        hold_n    = hold;
    endtask

    // Called just before the acceptance edge; follows the op through to hand-off
    task automatic complete_op();
        int lat;
        @(posedge clk); #1;
        junk_inputs();
        lat = 0;
        while (!out_valid && lat <= N + 2) begin
            check("busy_while_working", 32'(busy), 32'd1);
            check("in_ready_while_working", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
            junk_inputs();
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", 32'(result), 32'(exp_res));
        for (int h = 0; h < hold_n; h++) begin
            in_valid = 1'b1;
            i0       = 16'h1234;
            @(posedge clk); #1;
            check("out_valid_held", 32'(out_valid), 32'd1);
            check("result_held", 32'(result), 32'(exp_res));
            check("in_ready_held", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        i0        = N'($urandom);
        amount    = M'($urandom_range(1, N - 1));
        @(posedge clk); #1;
        check("out_valid_after_take", 32'(out_valid), 32'd0);
        check("in_ready_after_take", 32'(in_ready), 32'd1);
        check("busy_after_take", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [N-1:0] v, input int amt, input logic d, input int hold);
        @(posedge clk); #1;
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        drive_op(v, amt, d, hold);
        complete_op();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        i0        = '0;
        amount    = '0;
        dir       = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset_result", 32'(result), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);

        // First edge after release accepts the op (00FF ROR 4)
        drive_op(16'h00FF, 4, 1'b0, 0);
        #1 reset = 1'b0;
        complete_op();

        run_op(16'hFF00, 0, 1'b0, 0);
        run_op(16'h3C0C, 15, 1'b0, 0);
        run_op(16'hC003, 2, 1'b1, 3);
        run_op(16'h3C0C, 15, 1'b1, 1);
        run_op(16'h8001, 1, 1'b1, 0);
        run_op(16'h8001, 1, 1'b0, 2);

        // Reset mid-operation after 3 ROTATE edges
        @(posedge clk); #1;
        drive_op(16'h0AAA, 8, 1'b0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_result", 32'(result), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        #1 reset = 1'b0;
        run_op(16'h0AAA, 8, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            run_op(N'($urandom), int'($urandom_range(0, N - 1)), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
